beat_line_sequencer: RTL
========================

// Module: beat_line_sequencer
// PURPOSE
//  Frame-level controller for the beat counter. On a frame request it issues a
//  start pulse per line, waits for the counter to start and finish each line,
//  captures the line length, inserts a gap, and repeats until LINES lines are
//  done. Sits between the host/frame logic and the beat counter (drives its
//  startCounterEn; observes started, process and pixelCounter).
// PARAMETERS
//  LINES        128  lines per frame (>=1)
//  MINPIXEL     4    line length below this flags shortLine
//  GAP_CYCLES   4    idle cycles between end of line and next start (>=1)
//  START_WIDTH  1    cycles startCounterEn is held high per line (>=1)
//  TIMEOUT      64   max cycles to wait for started before FAULT
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  frameReq        in   1   level; sampled in IDLE only, starts a frame
//  abort           in   1   synchronous abort, highest priority after rst
//  started         in   1   beat counter has accepted start
//  process         in   1   beat counter is processing a line
//  pixelCounter    in   20  beat counter pixel count
//  startCounterEn  out  1   start strobe to beat counter
//  frameBusy       out  1   high from frame accept until frameDone/abort/FAULT
//  lineDone        out  1   1-cycle pulse at end of each line
//  shortLine       out  1   1-cycle pulse with lineDone if length < MINPIXEL
//  frameDone       out  1   1-cycle pulse after last line
//  fault           out  1   sticky; start timeout occurred
//  lineCount       out  8   lines completed in current frame
//  lastLineLen     out  20  pixelCounter captured at last line end
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal counters and processQ 0.
//  All outputs registered. processQ = process delayed 1 cycle.
//  lineEnd = processQ & ~process (falling edge of process).
//  States (3-bit): IDLE, ARM, WAIT_START, RUN, GAP, DONE, FAULT.
//  IDLE: frameReq=1 -> ARM; frameBusy<=1, lineCount<=0.
//  ARM: startCounterEn=1 for exactly START_WIDTH cycles -> WAIT_START.
//  WAIT_START: started=1 -> RUN. No started within TIMEOUT cycles -> FAULT.
//   started already high on ARM exit -> RUN next cycle.
//  RUN: on lineEnd: lastLineLen<=pixelCounter, lineDone pulse,
//   shortLine=(pixelCounter<MINPIXEL), lineCount+1; last line
//   (lineCount==LINES-1 before increment) -> DONE, else -> GAP.
//   process never rising in RUN is not an error; RUN waits indefinitely.
//  GAP: GAP_CYCLES cycles, then ARM.
//  DONE: frameDone=1 one cycle, frameBusy<=0 -> IDLE. lineCount holds
//   until next frame accept.
//  FAULT: fault=1, frameBusy=0, startCounterEn=0; leaves only on abort or rst.
//  abort=1 in any state: next cycle IDLE, startCounterEn=0, frameBusy=0,
//   fault cleared, no lineDone/frameDone pulse even if lineEnd coincides.
//  frameReq held high through DONE starts a new frame from IDLE (one
//   idle cycle between frames). frameReq outside IDLE is ignored.
//  rst mid-frame: immediate return to reset values (async).
//  lineCount width 8 wraps mod 256; LINES>255 unsupported.
// TESTING
//  1 LINES=3,GAP=4,START_WIDTH=2; frameReq pulse, model line of 10 pixels
//   -> 3 start strobes of 2 cycles, 3 lineDone, lastLineLen=10, frameDone once,
//   lineCount=3, >=4 idle cycles between line end and next strobe.
//  2 Model line of 2 pixels (MINPIXEL=4) -> shortLine with lineDone, len=2.
//  3 started never asserted, TIMEOUT=64 -> fault=1 at cycle 64 of WAIT_START,
//   frameBusy=0; abort -> fault=0, IDLE, new frame then accepted.
//  4 abort mid-RUN coincident with process fall -> no lineDone, no frameDone,
//   IDLE next cycle, lineCount unchanged.
//  5 rst asserted mid-GAP between clock edges -> all outputs 0 immediately.
//  6 frameReq held high -> back-to-back frames, frameDone every frame,
//   lineCount reset to 0 at each accept.

Source files
------------

// File: rtl/beat_line_sequencer.sv
// Frame-level controller for the beat counter: strobes a start per line, waits for
// the counter to start and finish, captures line length, inserts a gap, repeats.
module beat_line_sequencer #(
  parameter int LINES       = 128,
  parameter int MINPIXEL    = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int START_WIDTH = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frameReq,
  input  logic        i_abort,
  input  logic        i_started,
  input  logic        i_process,
  input  logic [19:0] i_pixelCounter,
  output logic        o_startCounterEn,
  output logic        o_frameBusy,
  output logic        o_lineDone,
  output logic        o_shortLine,
  output logic        o_frameDone,
  output logic        o_fault,
  output logic [7:0]  o_lineCount,
  output logic [19:0] o_lastLineLen
);

  localparam logic [7:0]  LAST_LINE  = 8'(LINES - 1);
  localparam logic [15:0] START_LAST = 16'(START_WIDTH - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_START, S_RUN, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t      r_state;
  logic        r_processQ;
  logic [15:0] r_cnt;
  logic        w_lineEnd;
  logic        w_short;

  // End of line is the falling edge of process.
  assign w_lineEnd = r_processQ & ~i_process;
  assign w_short   = i_pixelCounter < 20'(MINPIXEL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_processQ       <= 1'b0;
      r_cnt            <= '0;
      o_startCounterEn <= 1'b0;
      o_frameBusy      <= 1'b0;
      o_lineDone       <= 1'b0;
      o_shortLine      <= 1'b0;
      o_frameDone      <= 1'b0;
      o_fault          <= 1'b0;
      o_lineCount      <= '0;
      o_lastLineLen    <= '0;
    end else begin
      r_processQ  <= i_process;
      o_lineDone  <= 1'b0;
      o_shortLine <= 1'b0;
      o_frameDone <= 1'b0;
      // Abort overrides everything, including a line end in the same cycle.
      if (i_abort) begin
        r_state          <= S_IDLE;
        r_cnt            <= '0;
        o_startCounterEn <= 1'b0;
        o_frameBusy      <= 1'b0;
        o_fault          <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_frameReq) begin
              r_state          <= S_ARM;
              r_cnt            <= '0;
              o_startCounterEn <= 1'b1;
              o_frameBusy      <= 1'b1;
              o_lineCount      <= '0;
            end
          end
          S_ARM: begin
            if (r_cnt == START_LAST) begin
              r_state          <= S_WAIT_START;
              r_cnt            <= '0;
              o_startCounterEn <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_WAIT_START: begin
            if (i_started) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end else if (r_cnt == TO_LAST) begin
              r_state     <= S_FAULT;
              r_cnt       <= '0;
              o_fault     <= 1'b1;
              o_frameBusy <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_RUN: begin
            if (w_lineEnd) begin
              o_lastLineLen <= i_pixelCounter;
              o_lineDone    <= 1'b1;
              o_shortLine   <= w_short;
              o_lineCount   <= o_lineCount + 8'd1;
              r_cnt         <= '0;
              r_state       <= (o_lineCount == LAST_LINE) ? S_DONE : S_GAP;
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_state          <= S_ARM;
              r_cnt            <= '0;
              o_startCounterEn <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_DONE: begin
            r_state     <= S_IDLE;
            o_frameDone <= 1'b1;
            o_frameBusy <= 1'b0;
          end
          S_FAULT: begin
            o_fault          <= 1'b1;
            o_frameBusy      <= 1'b0;
            o_startCounterEn <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
